// File: rtl/edp_mpy_seq_pkg.sv
// Shared EBOX encodings for the EDP multiply sequencer: MQ shift function,
// AD operation, sequencer states and the step-count limit.
`timescale 1ns/1ps
package edp_mpy_seq_pkg;

  localparam logic [5:0] MAX_STEPS = 6'd36;

  // Same encoding the EDP MQ mux decodes.
  typedef enum logic [1:0] {
    MQ_LOAD = 2'd0,
    MQ_SHL  = 2'd1,
    MQ_SHR  = 2'd2,
    MQ_HOLD = 2'd3
  } mq_sel_e;

  typedef enum logic [1:0] {
    AD_PASS = 2'd0,
    AD_ADD  = 2'd1,
    AD_SUB  = 2'd2
  } ad_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [5:0] clamp_steps(input logic [5:0] steps);
    return (steps > MAX_STEPS) ? MAX_STEPS : steps;
  endfunction

endpackage

// File: rtl/edp_mpy_seq.sv
// Shift-add multiply sequencer for the EDP: drives MQ shift, AD op and
// BR/AR/ARX load enables through LOAD, N STEP cycles and a DONE pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs quiescent
// LOAD  | load BR and MQ, step counter holds min(steps,36)
// STEP  | one shift-add step per cycle, counter counts down
// DONE  | one-cycle completion pulse
`timescale 1ns/1ps
module edp_mpy_seq
  import edp_mpy_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic [5:0] steps,
  input  logic       signedMode,
  input  logic       mq35,
  input  logic       abort,
  output logic [1:0] mqSel,
  output logic [1:0] adOp,
  output logic       brLoad,
  output logic       arLoad,
  output logic       arxLoad,
  output logic       busy,
  output logic       done,
  output logic [5:0] stepCnt
);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  mq_sel_e    mq_sel;
  ad_op_e     ad_op;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mq_sel  = MQ_HOLD;
    ad_op   = AD_PASS;
    brLoad  = 1'b0;
    arLoad  = 1'b0;
    arxLoad = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          state_d = ST_LOAD;
          cnt_d   = clamp_steps(steps);
        end
      end
      ST_LOAD: begin
        brLoad  = 1'b1;
        mq_sel  = MQ_LOAD;
        state_d = (cnt_q != '0) ? ST_STEP : ST_DONE;
      end
      ST_STEP: begin
        arLoad  = 1'b1;
        arxLoad = 1'b1;
        mq_sel  = MQ_SHR;
        // Last step of a signed multiply subtracts to correct for the sign bit.
        if (mq35) ad_op = (signedMode && cnt_q == 6'd1) ? AD_SUB : AD_ADD;
        if (cnt_q != '0) cnt_d = cnt_q - 6'd1;
        if (cnt_q <= 6'd1) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign mqSel   = mq_sel;
  assign adOp    = ad_op;
  assign stepCnt = cnt_q;

  a_step_cnt_nonzero: assert property (
    @(posedge clk) disable iff (!rstN) !(state_q == ST_STEP && cnt_q == '0));

endmodule

// File: tb/tb_edp_mpy_seq.sv
// Randomized self-checking bench for edp_mpy_seq against a cycle-indexed
// reference model of the multiply sequence.
`timescale 1ns/1ps
module tb_edp_mpy_seq;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [5:0] steps;
  logic       signedMode;
  logic       mq35;
  logic       abort;
  logic [1:0] mqSel;
  logic [1:0] adOp;
  logic       brLoad, arLoad, arxLoad, busy, done;
  logic [5:0] stepCnt;

  int n_cmp = 0;
  int n_err = 0;

  edp_mpy_seq dut (
    .clk(clk), .rstN(rstN), .start(start), .steps(steps),
    .signedMode(signedMode), .mq35(mq35), .abort(abort),
    .mqSel(mqSel), .adOp(adOp), .brLoad(brLoad), .arLoad(arLoad),
    .arxLoad(arxLoad), .busy(busy), .done(done), .stepCnt(stepCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {mqSel, adOp, brLoad, arLoad, arxLoad, busy, done, stepCnt}
  function automatic logic [31:0] obs_word();
    return {17'd0, mqSel, adOp, brLoad, arLoad, arxLoad, busy, done, stepCnt};
  endfunction

  function automatic logic [31:0] pack(int mq, int ad, bit br, bit ar, bit busy_e,
                                       bit done_e, int cnt);
    logic [1:0] m = mq[1:0];
    logic [1:0] a = ad[1:0];
    logic [5:0] c = cnt[5:0];
    return {17'd0, m, a, br, ar, ar, busy_e, done_e, c};
  endfunction

  // Expected outputs c cycles after start is accepted, for an n-step multiply.
  // c==0 or c>n+2 means idle.
  function automatic logic [31:0] exp_word(int c, int n, bit sm, bit mq);
    int rem;
    int ad;
    if (c == 1) return pack(0, 0, 1, 0, 1, 0, n);
    if (c >= 2 && c <= n + 1) begin
      rem = n - (c - 2);
      ad  = !mq ? 0 : ((sm && rem == 1) ? 2 : 1);
      return pack(2, ad, 0, 1, 1, 0, rem);
    end
    if (c == n + 2) return pack(3, 0, 0, 0, 1, 1, 0);
    return pack(3, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic run_op(input string name, input logic [5:0] st, input bit sm,
                        input bit use_pat, input logic [35:0] pat, input int abort_c);
    int  n = (st > 6'd36) ? 36 : int'(st);
    bit  aborted = 0;
    @(negedge clk);
    start = 1'b1; steps = st; signedMode = sm; abort = 1'b0; mq35 = 1'($urandom);
    #1 chk({name, "/c0"}, obs_word(), exp_word(0, n, sm, mq35));
    for (int c = 1; c <= n + 2 && !aborted; c++) begin
      @(negedge clk);
      start = 1'($urandom);
      steps = 6'($urandom);
      signedMode = use_pat ? sm : 1'($urandom);
      mq35 = (use_pat && c >= 2 && c <= n + 1) ? pat[c-2] : 1'($urandom);
      abort = (c == abort_c);
      #1 chk($sformatf("%s/c%0d", name, c), obs_word(), exp_word(c, n, signedMode, mq35));
      aborted = abort;
    end
  endtask

  task automatic idle_cycle(input string name, input bit st, input bit ab);
    @(negedge clk);
    start = st; abort = ab; steps = 6'($urandom); mq35 = 1'($urandom);
    #1 chk(name, obs_word(), exp_word(0, 0, 0, 0));
  endtask

  initial begin
    int n;
    int ac;
    logic [5:0] st;
    rstN = 1'b0; start = 1'b0; steps = '0; signedMode = 1'b0; mq35 = 1'b0; abort = 1'b0;
    #2 chk("reset_state", obs_word(), exp_word(0, 0, 0, 0));
    @(posedge clk); @(posedge clk);
    #2 rstN = 1'b1;

    run_op("dir4", 6'd4, 1'b0, 1'b1, 36'b1101, 0);
    run_op("dir36s", 6'd36, 1'b1, 1'b1, {36{1'b1}}, 0);
    run_op("dir0", 6'd0, 1'b0, 1'b0, '0, 0);
    run_op("abort10", 6'd10, 1'b0, 1'b0, '0, 4);
    run_op("after_abort", 6'd5, 1'b0, 1'b0, '0, 0);
    idle_cycle("start_abort_idle", 1'b1, 1'b1);
    idle_cycle("stay_idle", 1'b0, 1'b0);

    // Asynchronous reset in the middle of a STEP cycle.
    @(negedge clk); start = 1'b1; steps = 6'd20; abort = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1 chk("rst_async", obs_word(), exp_word(0, 0, 0, 0));
    @(posedge clk);
    #1 chk("rst_held", obs_word(), exp_word(0, 0, 0, 0));
    @(posedge clk);
    #2 rstN = 1'b1;
    run_op("sat63", 6'd63, 1'b0, 1'b0, '0, 0);

    for (int i = 0; i < 30; i++) begin
      st = 6'($urandom_range(0, 63));
      n  = (st > 6'd36) ? 36 : int'(st);
      ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n + 2)) : 0;
      run_op($sformatf("rnd%0d", i), st, 1'($urandom), 1'b0, '0, ac);
    end
    idle_cycle("final_idle", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
